// File: rtl/gray_pos_tracker_pkg.sv
// Shared Gray-code definitions: tracker states, step-direction codes and a
// width-generic Gray-to-binary decoder usable by any Gray consumer.
package gray_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        FAULT    = 2'd2
    } tracker_state_e;

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam int GRAY_MAX_W = 32;

    // Callers zero-extend narrower codes; leading zeros decode to zeros.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_pos_tracker_if.sv
// Sample-in / record-out handshake bundle of the Gray position tracker.
interface gray_pos_tracker_if #(
    parameter int WIDTH     = 4,
    parameter int REV_WIDTH = 8
);
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_gray;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_bin;
    logic [1:0]           out_dir;
    logic [REV_WIDTH-1:0] out_rev;
    logic                 out_err;

    modport master (
        output clear, in_valid, in_gray, out_ready,
        input  in_ready, out_valid, out_bin, out_dir, out_rev, out_err
    );

    modport slave (
        input  clear, in_valid, in_gray, out_ready,
        output in_ready, out_valid, out_bin, out_dir, out_rev, out_err
    );
endinterface

// File: rtl/gray_pos_tracker_gray_to_bin.sv
// Combinational Gray-to-binary decoder for a WIDTH-bit code.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    assign bin = WIDTH'(gray2bin(GRAY_MAX_W'(gray)));
endmodule

// File: rtl/gray_pos_tracker.sv
// Decodes Gray position samples, classifies each step, counts revolutions and
// latches illegal jumps into a sticky fault until cleared.
module gray_pos_tracker
    import gray_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int REV_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    gray_pos_tracker_if.slave   bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    tracker_state_e       state, state_next;
    logic [WIDTH-1:0]     new_bin, prev_bin, delta;
    logic [REV_WIDTH-1:0] rev, rev_next;
    logic [1:0]           dir_next;
    logic                 err_next;
    logic                 accept;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_bin_q;
    logic [1:0]           out_dir_q;
    logic [REV_WIDTH-1:0] out_rev_q;
    logic                 out_err_q;

    gray_to_bin #(.WIDTH(WIDTH)) u_dec (
        .gray (bus.in_gray),
        .bin  (new_bin)
    );

    // clear blocks acceptance so a re-arm never coincides with a sample.
    assign bus.in_ready = !bus.clear && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign delta        = new_bin - prev_bin;

    always_comb begin
        state_next = state;
        rev_next   = rev;
        dir_next   = DIR_HOLD;
        err_next   = 1'b0;
        case (state)
            UNLOCKED: begin
                if (accept) state_next = LOCKED;
            end
            LOCKED: begin
                if (accept) begin
                    if (delta == '0) begin
                        dir_next = DIR_HOLD;
                    end else if (delta == ONE) begin
                        dir_next = DIR_UP;
                        if (new_bin == '0) rev_next = rev + REV_WIDTH'(1);
                    end else if (delta == ALL_ONES) begin
                        dir_next = DIR_DOWN;
                        if (new_bin == ALL_ONES) rev_next = rev - REV_WIDTH'(1);
                    end else begin
                        err_next   = 1'b1;
                        state_next = FAULT;
                    end
                end
            end
            FAULT: begin
                err_next = 1'b1;
            end
            default: state_next = UNLOCKED;
        endcase
        if (bus.clear) begin
            state_next = UNLOCKED;
            rev_next   = '0;
        end
    end

    // Output record holds its contents after retirement; only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= UNLOCKED;
            rev         <= '0;
            prev_bin    <= '0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_dir_q   <= DIR_HOLD;
            out_rev_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state <= state_next;
            rev   <= rev_next;
            if (accept) begin
                prev_bin    <= new_bin;
                out_valid_q <= 1'b1;
                out_bin_q   <= new_bin;
                out_dir_q   <= dir_next;
                out_rev_q   <= rev_next;
                out_err_q   <= err_next;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_bin   = out_bin_q;
    assign bus.out_dir   = out_dir_q;
    assign bus.out_rev   = out_rev_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: doc/gray_pos_tracker.md
# gray_pos_tracker

Decodes a stream of Gray-coded position samples (e.g. from an absolute encoder or a Gray-coded pointer) into binary. Tracks the direction of each step, counts wrap-arounds (revolutions), and flags illegal multi-step jumps. It is the receive-side counterpart of the team's binary-to-Gray encode path. It sits between the sampled Gray input and downstream binary consumers, using a valid/ready handshake on both sides.

## Interface
- WIDTH, 4, Gray/binary position width (≥2)
- REV_WIDTH, 8, revolution counter width
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- clear  input  1  synchronous re-arm pulse; returns tracker to UNLOCKED and zeroes revolution count
- in_valid  input  1  in_gray is valid
- in_ready  output  1  sample accepted when in_valid && in_ready
- in_gray  input  WIDTH  Gray-coded position sample
- out_valid  output  1  output record valid
- out_ready  input  1  downstream accepts record when out_valid && out_ready
- out_bin  output  WIDTH  decoded binary position
- out_dir  output  2  00 hold, 01 up, 10 down (11 unused)
- out_rev  output  REV_WIDTH  signed-wrap revolution count, modulo 2^REV_WIDTH
- out_err  output  1  sample was an illegal jump, or tracker is in FAULT

## Operation
- Conversion: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i] for i descending.
- in_ready = !clear && (!out_valid || out_ready). Single output register; no internal FIFO.
- prev_bin register holds the last accepted binary position. delta = new_bin − prev_bin mod 2^WIDTH.
- States:
  - UNLOCKED (reset): first accepted sample → out_dir=00, out_err=0, prev_bin loaded, go to LOCKED.
  - LOCKED:
    - delta=0 → dir 00.
    - delta=1 → dir 01; if prev_bin=all-ones and new_bin=0, rev+1.
    - delta=all-ones → dir 10; if prev_bin=0 and new_bin=all-ones, rev−1.
    - Any other delta → out_err=1, dir 00, rev unchanged, go to FAULT.
  - FAULT: samples still accepted and decoded. out_err=1, dir 00, rev frozen, prev_bin updated. Exit only via clear or rst.
- clear (any state): next state UNLOCKED, rev=0. in_ready is forced 0 that cycle, so no sample is lost or half-processed. A pending out_valid record is unaffected and still drains normally.
- rev arithmetic wraps modulo 2^REV_WIDTH (0 − 1 → all-ones).

## Timing
- Latency: accepted sample appears on outputs the next cycle (1 cycle).
- Throughput: 1 sample/cycle when out_ready held high.
- Output register holds value and out_valid stays 1 while out_ready=0. Outputs are stable under backpressure.
- Simultaneous out_ready and new accept in the same cycle: old record retires and the new record is loaded; out_valid stays 1.
- Reset values (cycle after rst high): out_valid=0, out_bin=0, out_dir=00, out_rev=0, out_err=0, prev_bin=0, state=UNLOCKED. in_ready=1 if clear=0.
- rst mid-stream discards the pending record and state. rst has priority over clear and accept.

## Structure
- Package gray_pkg holds:
  - enum of tracker states (UNLOCKED, LOCKED, FAULT);
  - dir localparams (DIR_HOLD=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10);
  - parameterized gray2bin function, shared with other Gray users.
- One sub-module is natural: gray_to_bin, combinational, parameter WIDTH, instantiated on in_gray.
- Top holds the FSM, prev_bin, revolution counter and output register.

## Test plan
- Reset, then in_gray=0000 → next cycle out_valid=1, out_bin=0, out_dir=00, out_rev=0, out_err=0.
- Stream 0000,0001,0011,0010,0110 back-to-back, out_ready=1 → out_bin 0,1,2,3,4; out_dir 00,01,01,01,01; one record per cycle.
- Up/down wrap:
  - lock at 1000 (15), then 0000 → out_bin=0, dir=01, rev=1.
  - then 1000 → bin=15, dir=10, rev=0.
  - then 0000 → rev=1.
- Illegal jump: lock at 0001 (1), send 0110 (4) → out_err=1, dir=00. Subsequent legal steps keep out_err=1, rev frozen. Pulse clear (in_ready=0 that cycle), then send 0111 → err=0, dir=00, rev=0.
- Backpressure: out_ready=0 with record pending → in_ready=0, out_* unchanged for 5 cycles. Raise out_ready with in_valid=1 → old record retires, new record visible the next cycle.
- Reset mid-stream at rev=3, out_valid=1 → next cycle all outputs 0 and state UNLOCKED. The first subsequent sample gives dir=00.
